// File: rtl/bech_mon_pkg.sv
// Shared types and constants for the bech controller output monitor.
package bech_mon_pkg;

    localparam int unsigned Y_W        = 39;
    localparam int unsigned PHASE_W    = 3;
    localparam int unsigned ERR_CODE_W = 3;

    // Decode phases; the numeric values are visible on the debug port.
    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE = 3'd0,
        PH_A2   = 3'd1,
        PH_A3   = 3'd2,
        PH_B2   = 3'd3,
        PH_B3   = 3'd4,
        PH_C2   = 3'd5
    } phase_e;

    // Violation codes; zero is only the reset value of err_code.
    localparam logic [ERR_CODE_W-1:0] ERR_NONE     = 3'd0;
    localparam logic [ERR_CODE_W-1:0] ERR_A2_MISS  = 3'd1;
    localparam logic [ERR_CODE_W-1:0] ERR_A3_MISS  = 3'd2;
    localparam logic [ERR_CODE_W-1:0] ERR_B2_MISS  = 3'd3;
    localparam logic [ERR_CODE_W-1:0] ERR_B3_MISS  = 3'd4;
    localparam logic [ERR_CODE_W-1:0] ERR_C_SILENT = 3'd5;
    localparam logic [ERR_CODE_W-1:0] ERR_C_MULTI  = 3'd6;
    localparam logic [ERR_CODE_W-1:0] ERR_C_PAIR   = 3'd7;

    // Bit positions of controller outputs y1..y39 within y_obs.
    localparam int unsigned Y1  = 0,  Y2  = 1,  Y3  = 2,  Y4  = 3,  Y5  = 4;
    localparam int unsigned Y6  = 5,  Y7  = 6,  Y8  = 7,  Y9  = 8,  Y10 = 9;
    localparam int unsigned Y11 = 10, Y12 = 11, Y13 = 12, Y14 = 13, Y15 = 14;
    localparam int unsigned Y16 = 15, Y17 = 16, Y18 = 17, Y19 = 18, Y20 = 19;
    localparam int unsigned Y21 = 20, Y22 = 21, Y23 = 22, Y24 = 23, Y25 = 24;
    localparam int unsigned Y26 = 25, Y27 = 26, Y28 = 27, Y29 = 28, Y30 = 29;
    localparam int unsigned Y31 = 30, Y32 = 31, Y33 = 32, Y34 = 33, Y35 = 34;
    localparam int unsigned Y36 = 35, Y37 = 36, Y38 = 37, Y39 = 38;

endpackage

// File: rtl/bech_mon_decode.sv
// Combinational pattern matcher: turns one y sample into per-step match flags.
module bech_mon_decode
    import bech_mon_pkg::*;
(
    input  logic [Y_W-1:0] y_obs,
    output logic           a1,
    output logic           a2,
    output logic           a3,
    output logic           b1,
    output logic           b2,
    output logic           b3,
    output logic           c1,
    output logic           c_zero,
    output logic           c_multi,
    output logic           c_pair_bad
);

    logic [3:0] c_grp;
    logic       unused_y;

    // C-branch group {y14, y11, y6, y5}
    assign c_grp = {y_obs[Y14], y_obs[Y11], y_obs[Y6], y_obs[Y5]};

    assign a1 = y_obs[Y35] & y_obs[Y36];
    assign a2 = y_obs[Y37] & y_obs[Y38];
    assign a3 = y_obs[Y3] & y_obs[Y28] & y_obs[Y34];
    assign b1 = y_obs[Y1];
    assign b2 = y_obs[Y2] & y_obs[Y3];
    assign b3 = y_obs[Y39];
    assign c1 = y_obs[Y4];

    assign c_zero     = (c_grp == 4'd0);
    // Clearing the lowest set bit leaves something only if two or more were set
    assign c_multi    = ((c_grp & (c_grp - 4'd1)) != 4'd0);
    assign c_pair_bad = y_obs[Y6] ^ y_obs[Y15];

    // Outputs not in any checked set are intentionally ignored
    assign unused_y = ^y_obs;

endmodule

// File: rtl/bech_out_monitor.sv
// Passive checker that decodes the bech controller's multi-cycle output sequences.
module bech_out_monitor
    import bech_mon_pkg::*;
#(
    parameter int unsigned ERR_CNT_W    = 8,
    parameter int unsigned ALARM_THRESH = 2,
    parameter int unsigned VISIT_CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sample_en,
    input  logic [Y_W-1:0]         y_obs,
    output logic                   err_pulse,
    output logic [ERR_CODE_W-1:0]  err_code,
    output logic [ERR_CNT_W-1:0]   err_count,
    output logic                   alarm,
    output logic [PHASE_W-1:0]     phase,
    output logic [VISIT_CNT_W-1:0] c_visits
);

    localparam logic [PHASE_W-1:0] S_IDLE = PH_IDLE;
    localparam logic [PHASE_W-1:0] S_A2   = PH_A2;
    localparam logic [PHASE_W-1:0] S_A3   = PH_A3;
    localparam logic [PHASE_W-1:0] S_B2   = PH_B2;
    localparam logic [PHASE_W-1:0] S_B3   = PH_B3;
    localparam logic [PHASE_W-1:0] S_C2   = PH_C2;

    logic [PHASE_W-1:0]     state;
    logic [PHASE_W-1:0]     state_nxt;
    logic                   err_hit;
    logic [ERR_CODE_W-1:0]  err_code_nxt;
    logic                   c_ok;
    logic [ERR_CNT_W-1:0]   err_count_nxt;
    logic [VISIT_CNT_W-1:0] c_visits_nxt;
    logic                   alarm_hit;

    logic a1, a2, a3, b1, b2, b3, c1, c_zero, c_multi, c_pair_bad;

    bech_mon_decode u_decode (
        .y_obs      (y_obs),
        .a1         (a1),
        .a2         (a2),
        .a3         (a3),
        .b1         (b1),
        .b2         (b2),
        .b3         (b3),
        .c1         (c1),
        .c_zero     (c_zero),
        .c_multi    (c_multi),
        .c_pair_bad (c_pair_bad)
    );

    // Next phase and violation classification for the current sample
    always_comb begin
        state_nxt    = state;
        err_hit      = 1'b0;
        err_code_nxt = err_code;
        c_ok         = 1'b0;
        if (sample_en) begin
            case (state)
                S_IDLE: begin
                    if (a1)      state_nxt = S_A2;
                    else if (b1) state_nxt = S_B2;
                    else if (c1) state_nxt = S_C2;
                end
                S_A2: begin
                    if (a2) begin
                        state_nxt = S_A3;
                    end else begin
                        state_nxt    = S_IDLE;
                        err_hit      = 1'b1;
                        err_code_nxt = ERR_A2_MISS;
                    end
                end
                S_A3: begin
                    state_nxt = S_IDLE;
                    if (!a3) begin
                        err_hit      = 1'b1;
                        err_code_nxt = ERR_A3_MISS;
                    end
                end
                S_B2: begin
                    if (b2) begin
                        state_nxt = S_B3;
                    end else begin
                        state_nxt    = S_IDLE;
                        err_hit      = 1'b1;
                        err_code_nxt = ERR_B2_MISS;
                    end
                end
                S_B3: begin
                    state_nxt = S_IDLE;
                    if (!b3) begin
                        err_hit      = 1'b1;
                        err_code_nxt = ERR_B3_MISS;
                    end
                end
                S_C2: begin
                    state_nxt = S_IDLE;
                    if (c_zero) begin
                        err_hit      = 1'b1;
                        err_code_nxt = ERR_C_SILENT;
                    end else if (c_pair_bad) begin
                        err_hit      = 1'b1;
                        err_code_nxt = ERR_C_PAIR;
                    end else if (c_multi) begin
                        err_hit      = 1'b1;
                        err_code_nxt = ERR_C_MULTI;
                    end else begin
                        c_ok = 1'b1;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Saturating counters and alarm threshold on the updated count
    always_comb begin
        err_count_nxt = err_count;
        c_visits_nxt  = c_visits;
        if (err_hit && (err_count != {ERR_CNT_W{1'b1}}))
            err_count_nxt = err_count + ERR_CNT_W'(1);
        if (c_ok && (c_visits != {VISIT_CNT_W{1'b1}}))
            c_visits_nxt = c_visits + VISIT_CNT_W'(1);
        alarm_hit = (32'(err_count_nxt) >= ALARM_THRESH);
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            err_pulse <= 1'b0;
            err_code  <= ERR_NONE;
            err_count <= '0;
            alarm     <= 1'b0;
            c_visits  <= '0;
        end else begin
            state     <= state_nxt;
            err_pulse <= err_hit;
            err_code  <= err_code_nxt;
            err_count <= err_count_nxt;
            alarm     <= alarm | alarm_hit;
            c_visits  <= c_visits_nxt;
        end
    end

    assign phase = state;

endmodule
